// File: rtl/periph_bus_arbiter_pkg.sv
// Shared types and widths for the two-master peripheral bus arbiter.
package periph_bus_arbiter_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned CNT_W           = 3;
    localparam int unsigned PERI_ARB_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // One master's access command as latched at grant time.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// Master-side handshakes and bridge-side bus of the peripheral arbiter.
interface periph_bus_arbiter_if;
    import periph_bus_arbiter_pkg::*;

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] addr_to_bridge;
    logic              we_to_bridge;
    logic [DATA_W-1:0] wdata_to_bridge;
    logic [DATA_W-1:0] rdata_from_bridge;

    // Arbiter view.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  rdata_from_bridge,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output addr_to_bridge, we_to_bridge, wdata_to_bridge
    );

    // Masters-plus-bridge view.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output rdata_from_bridge,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  addr_to_bridge, we_to_bridge, wdata_to_bridge
    );

endinterface

// File: rtl/periph_bus_arbiter_arb_rr2.sv
// Combinational 2-way round-robin picker: on a tie the master that did not win last time wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Single requester wins outright; a tie goes to the one not granted last.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares the bridge's single CPU-side port between two masters, one access at a time.
module periph_bus_arbiter
    import periph_bus_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT = PERI_ARB_RD_LAT
) (
    input  logic clk_from_cpu,
    input  logic rst_from_cpu,
    periph_bus_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              gnt_valid;
    logic              gnt_id;
    bus_req_t          m0_cmd;
    bus_req_t          m1_cmd;
    bus_req_t          gnt_cmd;

    arb_rr2 u_arb_rr2 (
        .req       ({bus.m1_req, bus.m0_req}),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Pick the granted master's command for latching.
    always_comb begin
        m0_cmd  = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
        m1_cmd  = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};
        gnt_cmd = gnt_id ? m1_cmd : m0_cmd;
    end

    // Next-state and next-register values; the write strobe and acks default low so each is one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    win_d   = gnt_id;
                    last_d  = gnt_id;
                    addr_d  = gnt_cmd.addr;
                    we_d    = gnt_cmd.we;
                    wdata_d = gnt_cmd.wdata;
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (win_q) begin
                        rdata1_d = bus.rdata_from_bridge;
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = bus.rdata_from_bridge;
                        ack0_d   = 1'b1;
                    end
                    addr_d  = '0;
                    wdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk_from_cpu) begin
        if (rst_from_cpu) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.addr_to_bridge  = addr_q;
    assign bus.we_to_bridge    = we_q;
    assign bus.wdata_to_bridge = wdata_q;
    assign bus.m0_ack          = ack0_q;
    assign bus.m1_ack          = ack1_q;
    assign bus.m0_rdata        = rdata0_q;
    assign bus.m1_rdata        = rdata1_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter at RD_LAT = 1, 0 and 7.
module tb_periph_bus_arbiter;

    localparam logic [31:0] KEY  = 32'hA5A5_0000;
    localparam logic [31:0] BASE = 32'hC000_0000;

    logic        clk;
    logic        rst;
    logic        bridge_auto;
    logic [31:0] bridge_data;
    logic [31:0] lat_data;
    int          checks;
    int          errors;

    periph_bus_arbiter_if bi ();
    periph_bus_arbiter_if bi0 ();
    periph_bus_arbiter_if bi7 ();

    periph_bus_arbiter #(.RD_LAT(1)) u_dut (
        .clk_from_cpu (clk),
        .rst_from_cpu (rst),
        .bus          (bi.slave)
    );

    periph_bus_arbiter #(.RD_LAT(0)) u_dut_lat0 (
        .clk_from_cpu (clk),
        .rst_from_cpu (rst),
        .bus          (bi0.slave)
    );

    periph_bus_arbiter #(.RD_LAT(7)) u_dut_lat7 (
        .clk_from_cpu (clk),
        .rst_from_cpu (rst),
        .bus          (bi7.slave)
    );

    // Bridge model: either a fixed value or a value derived from the presented address.
    assign bi.rdata_from_bridge  = bridge_auto ? (bi.addr_to_bridge ^ KEY) : bridge_data;
    assign bi0.rdata_from_bridge = lat_data;
    assign bi7.rdata_from_bridge = lat_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bi.m0_req = 0;  bi.m0_we = 0;  bi.m0_addr = '0;  bi.m0_wdata = '0;
        bi.m1_req = 0;  bi.m1_we = 0;  bi.m1_addr = '0;  bi.m1_wdata = '0;
        bi0.m0_req = 0; bi0.m0_we = 0; bi0.m0_addr = '0; bi0.m0_wdata = '0;
        bi0.m1_req = 0; bi0.m1_we = 0; bi0.m1_addr = '0; bi0.m1_wdata = '0;
        bi7.m0_req = 0; bi7.m0_we = 0; bi7.m0_addr = '0; bi7.m0_wdata = '0;
        bi7.m1_req = 0; bi7.m1_we = 0; bi7.m1_addr = '0; bi7.m1_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        checks++; if (bi.addr_to_bridge !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bi.addr_to_bridge); end
        checks++; if (bi.we_to_bridge !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bi.we_to_bridge); end
        checks++; if (bi.wdata_to_bridge !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bi.wdata_to_bridge); end
        checks++; if ({bi.m0_ack, bi.m1_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {bi.m0_ack, bi.m1_ack}); end
        checks++; if (bi.m0_rdata !== 32'h0) begin errors++; $display("FAIL reset_m0_rdata: got %h want 0", bi.m0_rdata); end
        checks++; if (bi.m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_m1_rdata: got %h want 0", bi.m1_rdata); end
        checks++; if (bi7.addr_to_bridge !== 32'h0 || bi0.m0_ack !== 1'b0) begin errors++; $display("FAIL reset_lat_duts: got addr7 %h ack0 %b want 0 0", bi7.addr_to_bridge, bi0.m0_ack); end
    endtask

    task automatic test_single_read();
        bridge_auto = 0;
        bridge_data = 32'h1234_5678;
        bi.m0_req = 1; bi.m0_we = 0; bi.m0_addr = 32'h0000_0040;
        step();
        checks++; if (bi.addr_to_bridge !== 32'h40) begin errors++; $display("FAIL read_addr_c1: got %h want 00000040", bi.addr_to_bridge); end
        checks++; if (bi.we_to_bridge !== 1'b0) begin errors++; $display("FAIL read_we_c1: got %b want 0", bi.we_to_bridge); end
        step();
        checks++; if (bi.m0_ack !== 1'b0) begin errors++; $display("FAIL read_early_ack: got %b want 0", bi.m0_ack); end
        step();
        checks++; if (bi.m0_ack !== 1'b1) begin errors++; $display("FAIL read_ack_c3: got %b want 1", bi.m0_ack); end
        checks++; if (bi.m0_rdata !== 32'h1234_5678) begin errors++; $display("FAIL read_rdata: got %h want 12345678", bi.m0_rdata); end
        checks++; if (bi.m1_ack !== 1'b0 || bi.m1_rdata !== 32'h0) begin errors++; $display("FAIL read_m1_hold: got ack %b rdata %h want 0 0", bi.m1_ack, bi.m1_rdata); end
        checks++; if (bi.addr_to_bridge !== 32'h0) begin errors++; $display("FAIL read_done_addr: got %h want 0", bi.addr_to_bridge); end
        bi.m0_req = 0;
        step();
        checks++; if (bi.m0_ack !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: got %b want 0", bi.m0_ack); end
    endtask

    task automatic test_single_write();
        int strobes;
        strobes = 0;
        bi.m1_req = 1; bi.m1_we = 1; bi.m1_addr = 32'hFFFF_F060; bi.m1_wdata = 32'h0000_00A5;
        step();
        checks++; if (bi.we_to_bridge !== 1'b1 || bi.wdata_to_bridge !== 32'hA5) begin errors++; $display("FAIL write_strobe_c1: got we %b wdata %h want 1 000000a5", bi.we_to_bridge, bi.wdata_to_bridge); end
        checks++; if (bi.addr_to_bridge !== 32'hFFFF_F060) begin errors++; $display("FAIL write_addr_c1: got %h want fffff060", bi.addr_to_bridge); end
        if (bi.we_to_bridge === 1'b1) strobes++;
        step();
        if (bi.we_to_bridge === 1'b1) strobes++;
        checks++; if (bi.m1_ack !== 1'b0) begin errors++; $display("FAIL write_early_ack: got %b want 0", bi.m1_ack); end
        step();
        if (bi.we_to_bridge === 1'b1) strobes++;
        checks++; if (bi.m1_ack !== 1'b1) begin errors++; $display("FAIL write_ack_c3: got %b want 1", bi.m1_ack); end
        checks++; if (bi.m0_rdata !== 32'h1234_5678 || bi.m0_ack !== 1'b0) begin errors++; $display("FAIL write_m0_hold: got rdata %h ack %b want 12345678 0", bi.m0_rdata, bi.m0_ack); end
        bi.m1_req = 0; bi.m1_we = 0;
        step();
        if (bi.we_to_bridge === 1'b1) strobes++;
        checks++; if (strobes != 1) begin errors++; $display("FAIL write_strobe_count: got %0d want 1", strobes); end
    endtask

    task automatic test_back_to_back();
        int nack;
        int cyc;
        int got_id;
        logic [31:0] got_rdata;
        logic [31:0] exp_rdata;
        bridge_auto = 1;
        rst = 1;
        step();
        rst = 0;
        bi.m0_req = 1; bi.m0_we = 0; bi.m0_addr = 32'h0000_0100;
        bi.m1_req = 1; bi.m1_we = 0; bi.m1_addr = 32'h0000_0200;
        nack = 0;
        cyc = 0;
        while (nack < 4 && cyc < 30) begin
            step();
            cyc++;
            if (bi.m0_ack === 1'b1 || bi.m1_ack === 1'b1) begin
                got_id    = (bi.m1_ack === 1'b1) ? 1 : 0;
                got_rdata = got_id ? bi.m1_rdata : bi.m0_rdata;
                exp_rdata = (nack % 2) ? (32'h0000_0200 ^ KEY) : (32'h0000_0100 ^ KEY);
                checks++; if (bi.m0_ack === 1'b1 && bi.m1_ack === 1'b1) begin errors++; $display("FAIL b2b_dual_ack: both acks high at cycle %0d", cyc); end
                checks++; if (got_id != nack % 2) begin errors++; $display("FAIL b2b_order[%0d]: got master %0d want %0d", nack, got_id, nack % 2); end
                checks++; if (cyc != 3 + 4 * nack) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", nack, cyc, 3 + 4 * nack); end
                checks++; if (got_rdata !== exp_rdata) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", nack, got_rdata, exp_rdata); end
                nack++;
                if (nack == 4) begin
                    bi.m0_req = 0;
                    bi.m1_req = 0;
                end
            end
        end
        checks++; if (nack != 4) begin errors++; $display("FAIL b2b_timeout: got %0d acks want 4", nack); end
        bi.m0_req = 0;
        bi.m1_req = 0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        bridge_auto = 1;
        bi.m0_req = 1; bi.m0_we = 0; bi.m0_addr = 32'h0000_0080;
        step();
        checks++; if (bi.addr_to_bridge !== 32'h80) begin errors++; $display("FAIL mid_busy_addr: got %h want 00000080", bi.addr_to_bridge); end
        rst = 1;
        bi.m0_req = 0;
        step();
        rst = 0;
        checks++; if (bi.addr_to_bridge !== 32'h0 || bi.we_to_bridge !== 1'b0 || bi.wdata_to_bridge !== 32'h0) begin errors++; $display("FAIL mid_bus_zero: got addr %h we %b wdata %h want 0 0 0", bi.addr_to_bridge, bi.we_to_bridge, bi.wdata_to_bridge); end
        checks++; if ({bi.m0_ack, bi.m1_ack} !== 2'b00 || bi.m0_rdata !== 32'h0 || bi.m1_rdata !== 32'h0) begin errors++; $display("FAIL mid_outputs_zero: got acks %b rdata0 %h rdata1 %h want 00 0 0", {bi.m0_ack, bi.m1_ack}, bi.m0_rdata, bi.m1_rdata); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bi.m0_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack[%0d]: got %b want 0", i, bi.m0_ack); end
        end
        bi.m0_req = 1; bi.m0_we = 0; bi.m0_addr = 32'h0000_0400;
        bi.m1_req = 1; bi.m1_we = 0; bi.m1_addr = 32'h0000_0500;
        step();
        step();
        step();
        checks++; if (bi.m0_ack !== 1'b1 || bi.m1_ack !== 1'b0) begin errors++; $display("FAIL mid_tie_winner: got acks m0 %b m1 %b want 1 0", bi.m0_ack, bi.m1_ack); end
        checks++; if (bi.m0_rdata !== (32'h0000_0400 ^ KEY)) begin errors++; $display("FAIL mid_tie_rdata: got %h want %h", bi.m0_rdata, 32'h0000_0400 ^ KEY); end
        bi.m0_req = 0;
        step();
        step();
        step();
        step();
        checks++; if (bi.m1_ack !== 1'b1) begin errors++; $display("FAIL mid_m1_ack: got %b want 1", bi.m1_ack); end
        checks++; if (bi.m1_rdata !== (32'h0000_0500 ^ KEY)) begin errors++; $display("FAIL mid_m1_rdata: got %h want %h", bi.m1_rdata, 32'h0000_0500 ^ KEY); end
        checks++; if (bi.m0_rdata !== (32'h0000_0400 ^ KEY)) begin errors++; $display("FAIL mid_m0_hold: got %h want %h", bi.m0_rdata, 32'h0000_0400 ^ KEY); end
        bi.m1_req = 0;
        step();
    endtask

    task automatic test_rd_lat();
        lat_data = BASE;
        bi0.m0_req = 1; bi0.m0_we = 0; bi0.m0_addr = 32'h0000_0010;
        bi7.m0_req = 1; bi7.m0_we = 0; bi7.m0_addr = 32'h0000_0010;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step();
            checks++; if (bi0.m0_ack !== (cyc == 2)) begin errors++; $display("FAIL lat0_ack_c%0d: got %b want %b", cyc, bi0.m0_ack, cyc == 2); end
            checks++; if (bi7.m0_ack !== (cyc == 9)) begin errors++; $display("FAIL lat7_ack_c%0d: got %b want %b", cyc, bi7.m0_ack, cyc == 9); end
            if (cyc == 2) begin
                checks++; if (bi0.m0_rdata !== BASE + 32'd1) begin errors++; $display("FAIL lat0_rdata: got %h want %h", bi0.m0_rdata, BASE + 32'd1); end
                bi0.m0_req = 0;
            end
            if (cyc == 9) begin
                checks++; if (bi7.m0_rdata !== BASE + 32'd8) begin errors++; $display("FAIL lat7_rdata: got %h want %h", bi7.m0_rdata, BASE + 32'd8); end
                bi7.m0_req = 0;
            end
            lat_data = BASE + 32'(cyc);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1;
        bridge_auto = 0;
        bridge_data = '0;
        lat_data    = '0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_reset_mid();
        test_rd_lat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
